// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time, and redirects/squashes on branches.
// Optional misaligned-target halt is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        flush
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        flush_q, flush_d;
  logic        trap_hit;
  logic [31:0] addr_out;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign trap_hit      = do_branch & (branch_target[1:0] != 2'b00);
  assign misalign_trap = trap_q;
  // The PC keeps the raw target; a misaligned one never reaches memory because the FSM halts.
  assign addr_out      = pc_q;
`else
  assign trap_hit      = 1'b0;
  assign addr_out      = {pc_q[31:2], 2'b00};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (do_branch) begin
      if (trap_hit) begin
        state_d = S_HALT;
      end else begin
        unique case (state_q)
          S_IDLE:  state_d = S_REQ;
          S_REQ:   state_d = imem_gnt ? S_DROP : S_REQ;
          S_RESP:  state_d = imem_rvalid ? S_REQ : S_DROP;
          S_HOLD:  state_d = S_REQ;
          // A response landing together with the redirect is the one DROP was waiting for.
          S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
          S_HALT:  state_d = S_HALT;
          default: state_d = S_REQ;
        endcase
      end
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = imem_gnt ? S_RESP : S_REQ;
        S_RESP:  state_d = imem_rvalid ? S_HOLD : S_RESP;
        S_HOLD:  state_d = (if_valid_q && if_ready) ? S_REQ : S_HOLD;
        S_DROP:  state_d = imem_rvalid ? S_REQ : S_DROP;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = addr_out;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign flush     = flush_q;

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    flush_d    = do_branch;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d     = trap_q | trap_hit;
`endif
    if (do_branch) begin
      pc_d       = branch_target;
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = addr_out;
          end
        end
        S_RESP: begin
          if (imem_rvalid) begin
            if_instr_d = imem_rdata;
            if_pc_d    = req_pc_q;
            if_valid_d = 1'b1;
          end
        end
        S_HOLD: begin
          if (if_valid_q && if_ready) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
      flush_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      flush_q    <= flush_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q     <= trap_d;
`endif
    end
  end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end of the RISC-V core. Owns the PC, issues word fetches to instruction memory and presents fetched instructions to decode over a valid/ready handshake.
- Consumes `do_branch`/`branch_target` from the execute-stage branch comparator and redirects fetch to the target.
- Squashes younger work by raising `flush` and discarding any in-flight memory response.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on `if_instr` when no instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- do_branch  input  1  execute stage: redirect this cycle.
- branch_target  input  32  redirect address, valid when `do_branch`=1.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch word address.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  response instruction word.
- if_valid  output  1  instruction held for decode.
- if_pc  output  32  PC of held instruction.
- if_instr  output  32  held instruction.
- if_ready  input  1  decode accepts this cycle.
- flush  output  1  one-cycle squash pulse to decode/execute.

Behaviour:
- Reset (`rst`=1 at a clock edge): `pc`=RESET_PC, state=IDLE, `imem_req`=0, `if_valid`=0, `if_pc`=0, `if_instr`=NOP_INSTR, `flush`=0. Reset mid-transaction abandons any outstanding response; an `imem_rvalid` arriving afterwards is ignored.
- Memory protocol:
  - At most one outstanding request.
  - A request is accepted on a cycle with `imem_req` & `imem_gnt`.
  - The response arrives on a later cycle, in order, as `imem_rvalid`.
  - `imem_addr`=`pc` whenever `imem_req`=1.
  - `pc` increments by 4 on acceptance; the accepted address is latched as `req_pc`.
- States:
  - IDLE: `imem_req`=0. Next state is REQ. This gives exactly one idle cycle after reset release.
  - REQ: `imem_req`=1. On `imem_gnt`, go to RESP. Before grant, `imem_addr` may change only because of a redirect.
  - RESP: `imem_req`=0. On `imem_rvalid`, register `if_instr`<=`imem_rdata`, `if_pc`<=`req_pc`, `if_valid`<=1, then go to HOLD.
  - HOLD: `if_valid`=1, outputs stable. On `if_valid` & `if_ready`, clear `if_valid`, set `if_instr`<=NOP_INSTR, and go to REQ.
  - DROP: `imem_req`=0. Wait for `imem_rvalid`, discard its data, then go to REQ.
- Best-case throughput: one instruction per 3 cycles (REQ→RESP→HOLD). Prefetch is out of scope.
- Redirect (`do_branch`=1) has top priority over every other event in the same cycle:
  - `pc`<=`branch_target`.
  - `if_valid`<=0 and `if_instr`<=NOP_INSTR.
  - `flush` is registered: high exactly one cycle, the cycle after `do_branch`.
  - From REQ without grant: stay in REQ; the next cycle requests `branch_target`.
  - From REQ with grant in the same cycle: the granted request belongs to the old path, go to DROP.
  - From RESP with no `imem_rvalid`: go to DROP.
  - From RESP with `imem_rvalid` in the same cycle: discard the data, go to REQ.
  - From HOLD: go to REQ, whether or not `if_ready` is high. A handshake completing in that same cycle is squashed by the following `flush`, and decode must discard it.
  - From IDLE or DROP: IDLE goes to REQ; DROP stays in DROP.
  - Back-to-back `do_branch`: the last target wins; `flush` stays high for each cycle following a `do_branch` cycle.
- `imem_rvalid` in IDLE, REQ or HOLD is a protocol error and is ignored.
- `branch_target` is used as given; bits [1:0] are forced to 0 on `imem_addr` only when the optional feature is disabled.
- All PC arithmetic is 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output `misalign_trap` (1 bit, reset 0).
  - On `do_branch` with `branch_target`[1:0]≠0: `misalign_trap`<=1 (sticky until `rst`), `flush` pulses as normal, and the FSM enters HALT.
  - HALT: `imem_req`=0 and `if_valid`=0 until reset. An outstanding response is still absorbed.
- Undefined: no port; bits [1:0] are cleared and fetch proceeds.

Test Plan:
- Reset release with RESET_PC=0, `imem_gnt`=1, `imem_rvalid` 1 cycle after grant, `if_ready`=1 → `imem_addr` sequence 0,4,8; `if_pc`=0,4,8 every 3 cycles; `flush` stays 0.
- `if_ready`=0 for 5 cycles while in HOLD with `if_instr`=32'h00A00093 → outputs stable, `imem_req`=0, `pc` stays 4.
- `do_branch`=1, target 32'h100, while in RESP; stale `imem_rvalid` arrives 2 cycles later → data dropped, `flush` high 1 cycle, next `imem_addr`=32'h100, `if_pc`=32'h100.
- `do_branch` in the same cycle as `if_valid`&`if_ready` in HOLD, target 32'h40 → `flush` pulses, next request is 32'h40.
- `rst` asserted in RESP, old `imem_rvalid` arrives during IDLE → ignored; first `if_pc`=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN: target 32'h102 → `misalign_trap`=1, `imem_req` stays 0 for 20 cycles. Without the macro: `imem_addr`=32'h100.
